// File: rtl/qsys_block_nios_oci_trace_monitor.sv
// rtl/qsys_block_nios_oci_trace_monitor.sv - OCI trace capture into a circular buffer, drained on test end
module qsys_block_nios_oci_trace_monitor #(
  parameter int DATA_W = 30,
  parameter int CNT_W  = 4,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] dct_buffer,
  input  logic [CNT_W-1:0]  dct_count,
  input  logic              test_ending,
  input  logic              test_has_ended,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic [ADDR_W:0]   fill_level,
  output logic              overflow,
  output logic [15:0]       drop_count,
  output logic [1:0]        state,
  output logic              done
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] FILL_ONE   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  typedef enum logic [1:0] {
    CAPTURE = 2'b00,
    DRAIN   = 2'b01,
    DONE    = 2'b10
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   fill_q, fill_after_pop;
  logic [CNT_W-1:0]  prev_count;
  logic              cap_event, is_full, do_write, do_pop;

  assign cap_event = (dct_count != prev_count);
  assign is_full   = (fill_q == FULL_LEVEL);
  assign do_write  = (state_q == CAPTURE) && cap_event;
  assign rd_valid  = (state_q == DRAIN) && (fill_q != '0);
  assign do_pop    = rd_valid && rd_ready;
  assign rd_data   = mem[rd_ptr];
  assign rd_last   = rd_valid && (fill_q == FILL_ONE);

  assign fill_level = fill_q;
  assign state      = state_q;
  assign done       = (state_q == DONE);

  // DONE is judged on the level left after this cycle's pop.
  assign fill_after_pop = do_pop ? (fill_q - FILL_ONE) : fill_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      CAPTURE: if (test_ending || test_has_ended) state_d = DRAIN;
      DRAIN:   if (test_has_ended && (fill_after_pop == '0)) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = CAPTURE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= CAPTURE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_q     <= '0;
      prev_count <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      state_q    <= state_d;
      prev_count <= dct_count;
      if (do_write) begin
        wr_ptr <= wr_ptr + PTR_ONE;
        if (is_full) begin
          // Full buffer keeps the newest DEPTH words: the oldest is lost.
          rd_ptr   <= rd_ptr + PTR_ONE;
          overflow <= 1'b1;
          if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
        end else begin
          fill_q <= fill_q + FILL_ONE;
        end
      end else if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        fill_q <= fill_q - FILL_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr] <= dct_buffer;
  end

endmodule

// File: doc/qsys_block_nios_oci_trace_monitor.md
# qsys_block_nios_oci_trace_monitor

Parametrised simulation-side successor to the Nios OCI test-bench hook. It watches the OCI debug-capture trace interface (`dct_buffer`/`dct_count`) and captures each new trace word into a circular buffer. On test end it drains the buffer to the bench through a valid/ready port. It sits beside the Nios OCI debug block in the qsys_block hierarchy and reports overflow, drop count and completion.

## Interface
- `DATA_W`, 30: width of `dct_buffer` and `rd_data`.
- `CNT_W`, 4: width of `dct_count`.
- `ADDR_W`, 4: buffer address width; depth = 2**ADDR_W (16).
- `clk` in 1: single clock, all logic rising-edge.
- `reset_n` in 1: reset, asynchronous and active-low.
- `dct_buffer` in DATA_W: trace word from OCI.
- `dct_count` in CNT_W: OCI trace count; any change is a capture event.
- `test_ending` in 1: level/pulse, starts drain.
- `test_has_ended` in 1: level/pulse, final end-of-test indication.
- `rd_ready` in 1: bench accepts `rd_data`.
- `rd_valid` out 1: `rd_data` holds the oldest unread entry.
- `rd_data` out DATA_W: oldest entry.
- `rd_last` out 1: `rd_valid` and this is the final entry (fill = 1).
- `fill_level` out ADDR_W+1: entries held, 0..2**ADDR_W.
- `overflow` out 1: sticky, an entry was overwritten.
- `drop_count` out 16: overwritten entries, saturates at 16'hFFFF.
- `state` out 2: 2'b00 CAPTURE, 2'b01 DRAIN, 2'b10 DONE.
- `done` out 1: state == DONE.

## Operation
- Reset values:
  - state CAPTURE.
  - Write and read pointers 0; `fill_level` 0.
  - `overflow` 0, `drop_count` 0, `done` 0.
  - `rd_valid`/`rd_last` 0; `rd_data` = mem[0] (don't-care).
  - `prev_count` register 0.
- Capture event: `dct_count != prev_count`. `prev_count` loads `dct_count` every cycle in every state.
  - Multi-step jumps in `dct_count` count as one event.
  - A constant 0 after reset produces no event.
- CAPTURE, event, not full: write `dct_buffer` at wr_ptr; wr_ptr+1 (mod depth); fill+1.
- CAPTURE, event, full: overwrite oldest at wr_ptr. wr_ptr and rd_ptr both +1 (mod depth); fill stays 2**ADDR_W. `overflow` set; `drop_count` +1 with saturation.
- Pointers wrap modulo 2**ADDR_W with no gap.
- Transitions:
  - CAPTURE -> DRAIN when `test_ending` or `test_has_ended` is 1. An event in that same cycle is still captured.
  - DRAIN -> DONE when fill = 0 and `test_has_ended` = 1, evaluated after any pop in that cycle.
  - DONE holds until reset.
- DRAIN:
  - Events are ignored: no write, no drop count.
  - `rd_valid` = (fill != 0).
  - Pop on `rd_valid && rd_ready`: rd_ptr+1, fill-1.
  - `rd_ready` with fill 0 has no effect.
- DONE: no writes or pops; `rd_valid` 0; `done` 1.
- The `overflow`/`drop_count` values are retained through DRAIN/DONE.
- Reset asserted mid-capture or mid-drain returns immediately, asynchronously, to the reset values listed above. Buffer contents are not cleared but are unreachable.

## Timing
- Capture: an event sampled at edge N is written at edge N. `fill_level` and `drop_count` reflect it after edge N.
- `rd_data`, `rd_valid` and `rd_last` are combinational from registered pointers/fill: valid the same cycle state enters DRAIN with fill > 0.
- One pop per cycle max. Back-to-back pops with `rd_ready` held high drain N entries in N cycles.
- `rd_data` must stay stable while `rd_valid && !rd_ready`.
- `state` changes one edge after the qualifying input. `done` rises the edge after the last pop when `test_has_ended` is already high. If `test_has_ended` arrives later, `done` rises one edge after it.

## Test plan
- Reset, step `dct_count` 0->1->2->3 with `dct_buffer` = 0x100, 0x101, 0x102, assert `test_ending`, `rd_ready`=1 -> fill 3; reads 0x100, 0x101, 0x102; `rd_last` on 0x102; `overflow` 0.
- 20 events (data 0..19), depth 16, then drain -> `overflow` 1, `drop_count` 4, reads 4..19 in order, fill 16 at drain start.
- Event in the same cycle as `test_ending` -> that word is captured; events in DRAIN -> fill unchanged, `drop_count` unchanged.
- DRAIN with 2 entries, `rd_ready` toggled 1,0,0,1 -> `rd_data` stable while stalled; exactly 2 pops; `test_has_ended` held high -> `done` 1 the edge after the second pop.
- Drop `reset_n` mid-drain with fill 5 -> outputs return to reset values immediately (fill 0, `rd_valid` 0, state CAPTURE). After release, `dct_count` held at its pre-reset nonzero value produces one event.
- `test_has_ended` asserted alone in CAPTURE with fill 0 -> DRAIN next edge, DONE the following edge, `rd_valid` never 1.
